// File: rtl/board_pattern_gen_pkg.sv
// Shared mode encoding for the board bring-up pattern generator.
package board_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_WALK   = 2'd0;
    localparam mode_t MODE_FLASH  = 2'd1;
    localparam mode_t MODE_COUNT  = 2'd2;
    localparam mode_t MODE_BOUNCE = 2'd3;

endpackage

// File: rtl/board_pattern_gen_button_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stable-count debounce and
// a one-cycle press pulse on each accepted 0->1 transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // The cycle that completes the stable run accepts the new level.
                r_cnt   <= '0;
                r_level <= ~r_level;
                r_press <= ~r_level;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_press = r_press;

endmodule

// File: rtl/board_pattern_gen.sv
// Board bring-up pattern generator: four selectable patterns on CHANNELS pins,
// stepped by a prescaler, with debounced mode and pause buttons.
module board_pattern_gen
    import board_pkg::*;
#(
    parameter int CHANNELS        = 48,
    parameter int TICK_DIV        = 240000,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                button_next,
    input  logic                button_pause,
    output logic [CHANNELS-1:0] pattern,
    output logic                blink,
    output logic                tick,
    output logic [1:0]          mode,
    output logic                paused,
    output logic [1:0]          buttons_db
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
    localparam logic [CHANNELS-1:0] PAT_ONE  = CHANNELS'(1);

    logic                w_next_level;
    logic                w_next_press;
    logic                w_pause_level;
    logic                w_pause_press;
    logic                w_blink_next;
    logic                w_bounce_dir;
    logic [CHANNELS-1:0] w_bounce_pat;
    logic [CHANNELS-1:0] w_step_pat;
    mode_t               w_mode_next;

    logic [CHANNELS-1:0] r_pattern;
    logic [PRE_W-1:0]    r_presc;
    logic                r_blink;
    logic                r_tick;
    logic                r_paused;
    logic                r_dir_up;
    mode_t               r_mode;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk       (clk),
        .resetn    (resetn),
        .btn_raw   (button_next),
        .btn_level (w_next_level),
        .btn_press (w_next_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk       (clk),
        .resetn    (resetn),
        .btn_raw   (button_pause),
        .btn_level (w_pause_level),
        .btn_press (w_pause_press)
    );

    function automatic logic [CHANNELS-1:0] mode_seed(input mode_t m);
        return (m == MODE_WALK || m == MODE_BOUNCE) ? PAT_ONE : '0;
    endfunction

    assign w_blink_next = ~r_blink;
    assign w_mode_next  = r_mode + 2'd1;

    // Direction flips on the step that lands on an end bit, so each end holds one tick.
    always_comb begin
        w_bounce_pat = r_pattern;
        w_bounce_dir = r_dir_up;
        if (CHANNELS > 1) begin
            if (r_dir_up) begin
                w_bounce_pat = r_pattern << 1;
                w_bounce_dir = ~w_bounce_pat[CHANNELS-1];
            end else begin
                w_bounce_pat = r_pattern >> 1;
                w_bounce_dir = w_bounce_pat[0];
            end
        end
    end

    always_comb begin
        w_step_pat = r_pattern;
        case (r_mode)
            MODE_WALK:  w_step_pat = {r_pattern[0], r_pattern[CHANNELS-1:1]};
            MODE_FLASH: w_step_pat = {CHANNELS{w_blink_next}};
            MODE_COUNT: w_step_pat = r_pattern + PAT_ONE;
            default:    w_step_pat = w_bounce_pat;
        endcase
    end

    // A next press pre-empts any step in the same cycle, paused or not.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pattern <= PAT_ONE;
            r_presc   <= '0;
            r_blink   <= 1'b0;
            r_tick    <= 1'b0;
            r_paused  <= 1'b0;
            r_dir_up  <= 1'b1;
            r_mode    <= MODE_WALK;
        end else begin
            r_tick <= 1'b0;
            if (w_pause_press) begin
                r_paused <= ~r_paused;
            end
            if (w_next_press) begin
                r_mode    <= w_mode_next;
                r_pattern <= mode_seed(w_mode_next);
                r_dir_up  <= 1'b1;
                r_presc   <= '0;
            end else if (!r_paused) begin
                if (r_presc == PRE_LAST) begin
                    r_presc   <= '0;
                    r_tick    <= 1'b1;
                    r_blink   <= w_blink_next;
                    r_pattern <= w_step_pat;
                    if (r_mode == MODE_BOUNCE) begin
                        r_dir_up <= w_bounce_dir;
                    end
                end else begin
                    r_presc <= r_presc + PRE_ONE;
                end
            end
        end
    end

    assign pattern    = r_pattern;
    assign blink      = r_blink;
    assign tick       = r_tick;
    assign mode       = r_mode;
    assign paused     = r_paused;
    assign buttons_db = {w_pause_level, w_next_level};

endmodule

// File: tb/tb_board_pattern_gen.sv
// Scoreboard bench for board_pattern_gen (CHANNELS=8, TICK_DIV=4, DEBOUNCE_CYCLES=3).
module tb_board_pattern_gen;

    logic       clk = 1'b0;
    logic       resetn;
    logic       button_next;
    logic       button_pause;
    logic [7:0] pattern;
    logic       blink;
    logic       tick;
    logic [1:0] mode;
    logic       paused;
    logic [1:0] buttons_db;

    typedef struct packed {
        logic [7:0] pat;
        logic       blk;
        logic [1:0] md;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic       exp_blk;
    logic [7:0] exp_pat;
    logic [7:0] bnc_tab[16];
    int         cyc;
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    board_pattern_gen #(
        .CHANNELS        (8),
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .button_next  (button_next),
        .button_pause (button_pause),
        .pattern      (pattern),
        .blink        (blink),
        .tick         (tick),
        .mode         (mode),
        .paused       (paused),
        .buttons_db   (buttons_db)
    );

    // Edge counter relative to the last reset release.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " pattern"}, {24'd0, pattern}, 32'h01);
        check({tag, " blink"}, {31'd0, blink}, 32'd0);
        check({tag, " tick"}, {31'd0, tick}, 32'd0);
        check({tag, " mode"}, {30'd0, mode}, 32'd0);
        check({tag, " paused"}, {31'd0, paused}, 32'd0);
        check({tag, " buttons_db"}, {30'd0, buttons_db}, 32'd0);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] p, input logic [1:0] m);
        exp_blk = ~exp_blk;
        exp_q.push_back({p, exp_blk, m});
    endtask

    task automatic push_walk(input int n);
        for (int i = 0; i < n; i++) begin
            exp_pat = {exp_pat[0], exp_pat[7:1]};
            push(exp_pat, 2'd0);
        end
    endtask

    task automatic push_flash(input int n);
        for (int i = 0; i < n; i++) push({8{~exp_blk}}, 2'd1);
    endtask

    task automatic push_count(input int n);
        for (int i = 0; i < n; i++) begin
            exp_pat = exp_pat + 8'd1;
            push(exp_pat, 2'd2);
        end
    endtask

    // Monitor: every tick pops the next expected step.
    always @(negedge clk) begin
        if (resetn === 1'b1 && tick === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected tick at cyc %0d: pattern %0h mode %0d", cyc, pattern, mode);
            end else begin
                mon_e = exp_q.pop_front();
                if ({pattern, blink, mode} !== mon_e) begin
                    n_fail++;
                    $display("FAIL tick step at cyc %0d: got pat=%0h blink=%0b mode=%0d, expected pat=%0h blink=%0b mode=%0d",
                             cyc, pattern, blink, mode, mon_e.pat, mon_e.blk, mon_e.md);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bnc_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        resetn       = 1'b0;
        button_next  = 1'b0;
        button_pause = 1'b0;

        exp_blk = 1'b0;
        exp_pat = 8'h01; push_walk(13);
        push_flash(3);
        exp_pat = 8'h00; push_count(259);
        for (int i = 0; i < 16; i++) push(bnc_tab[i], 2'd3);
        exp_pat = 8'h01; push_walk(2);
        push_flash(2);
        exp_pat = 8'h00; push_count(3);

        repeat (3) @(negedge clk);
        chk_reset("reset");
        resetn = 1'b1;

        // Walk for 40 clocks, then a 2-clock glitch on next.
        wait_cyc(40);
        check("walk mode", {30'd0, mode}, 32'd0);
        button_next = 1'b1;
        wait_cyc(42);
        button_next = 1'b0;
        wait_cyc(44);
        check("glitch db", {30'd0, buttons_db}, 32'd0);
        wait_cyc(48);
        check("glitch mode", {30'd0, mode}, 32'd0);

        // Real press: level at +5 edges, mode change one edge later.
        button_next = 1'b1;
        wait_cyc(52);
        check("db before stable", {30'd0, buttons_db}, 32'd0);
        wait_cyc(53);
        check("db after stable", {30'd0, buttons_db}, 32'd1);
        check("mode before press", {30'd0, mode}, 32'd0);
        wait_cyc(54);
        check("flash entry", {22'd0, mode, pattern}, {22'd0, 2'd1, 8'h00});
        wait_cyc(58);
        button_next = 1'b0;

        // Next press lands on a prescaler wrap: mode change wins, no tick.
        wait_cyc(64);
        button_next = 1'b1;
        wait_cyc(70);
        check("count entry", {22'd0, mode, pattern}, {22'd0, 2'd2, 8'h00});
        check("wrap vs next tick", {31'd0, tick}, 32'd0);
        check("wrap vs next blink", {31'd0, blink}, 32'd0);
        wait_cyc(71);
        button_next = 1'b0;

        wait_cyc(1102);
        button_next = 1'b1;
        wait_cyc(1108);
        check("bounce entry", {22'd0, mode, pattern}, {22'd0, 2'd3, 8'h01});
        wait_cyc(1109);
        button_next = 1'b0;

        wait_cyc(1168);
        button_next = 1'b1;
        wait_cyc(1174);
        check("walk re-entry", {22'd0, mode, pattern}, {22'd0, 2'd0, 8'h01});
        wait_cyc(1175);
        button_next = 1'b0;

        // Pause in walk mode, then a next press while paused.
        wait_cyc(1178);
        button_pause = 1'b1;
        wait_cyc(1184);
        check("paused set", {31'd0, paused}, 32'd1);
        check("paused pattern", {24'd0, pattern}, 32'h40);
        wait_cyc(1185);
        button_pause = 1'b0;
        for (int i = 0; i < 89; i++) begin
            @(negedge clk);
            check("frozen", {22'd0, tick, blink, pattern}, {22'd0, 1'b0, 1'b1, 8'h40});
        end
        button_next = 1'b1;
        wait_cyc(1280);
        check("paused next", {20'd0, paused, tick, blink, mode, pattern},
              {20'd0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h00});
        wait_cyc(1281);
        button_next = 1'b0;
        wait_cyc(1284);
        check("paused after next", {22'd0, tick, blink, pattern}, {22'd0, 1'b0, 1'b1, 8'h00});
        button_pause = 1'b1;
        wait_cyc(1289);
        check("still paused", {31'd0, paused}, 32'd1);
        wait_cyc(1290);
        check("resumed", {31'd0, paused}, 32'd0);
        wait_cyc(1291);
        button_pause = 1'b0;

        // Into count mode, pause, then async reset off the clock edge.
        wait_cyc(1294);
        button_next = 1'b1;
        wait_cyc(1300);
        check("count again", {22'd0, mode, pattern}, {22'd0, 2'd2, 8'h00});
        wait_cyc(1301);
        button_next = 1'b0;
        wait_cyc(1308);
        button_pause = 1'b1;
        wait_cyc(1314);
        check("paused in count", {31'd0, paused}, 32'd1);
        wait_cyc(1315);
        button_pause = 1'b0;
        wait_cyc(1320);
        check("count frozen", {21'd0, paused, tick, mode, pattern},
              {21'd0, 1'b1, 1'b0, 2'd2, 8'h03});
        check("scoreboard drained", exp_q.size(), 32'd0);

        #2 resetn = 1'b0;
        #1 chk_reset("async reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check("restart pattern", {24'd0, pattern}, 32'h01);
        exp_blk = 1'b0;
        exp_pat = 8'h01;
        push_walk(3);
        wait_cyc(13);
        check("restart mode", {30'd0, mode}, 32'd0);
        check("restart drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
